mac_dot_sequencer: RTL

- Command-side driver for the 16x16 signed MAC unit (instruction/multiplier/multiplicand/stall in; 8-bit protect plus 32-bit result out).
- Accepts a dot-product job of LEN operand pairs over a valid/ready stream and issues the MAC instruction sequence: multiply, then accumulate, then optional saturate.
- Captures the 40-bit {protect,result} and returns it on a valid/ready result port with an overflow flag.
- Sits between the DSP job controller and one MAC instance.

---
 rtl/mac_dot_sequencer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mac_dot_sequencer.sv
// Sequences one dot-product job into a 16x16 signed MAC: multiply, accumulate, optional saturate.
// Captures {protect,result} MAC_LAT+1 edges after the final instruction and holds it until consumed.
module mac_dot_sequencer #(
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             sat_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    output logic [2:0]       mac_instruction,
    output logic [15:0]      mac_multiplier,
    output logic [15:0]      mac_multiplicand,
    output logic             mac_stall,
    input  logic [7:0]       mac_protect,
    input  logic [31:0]      mac_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [39:0]      out_data,
    output logic             out_ovf,
    output logic             busy
);

    localparam int WCNT_W = $clog2(MAC_LAT + 2);
    localparam logic [2:0] OP_CLR = 3'b000;
    localparam logic [2:0] OP_MUL = 3'b001;
    localparam logic [2:0] OP_ACC = 3'b010;
    localparam logic [2:0] OP_SAT = 3'b011;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_WAIT, S_HOLD} state_t;

    state_t              r_state, w_state;
    logic [LEN_W-1:0]    r_cnt, w_cnt;
    logic                r_first, w_first;
    logic                r_sat_en, w_sat_en;
    logic [WCNT_W-1:0]   r_wcnt, w_wcnt;
    logic [2:0]          r_instr, w_instr;
    logic [15:0]         r_mult, w_mult;
    logic [15:0]         r_mcand, w_mcand;
    logic                r_stall, w_stall;
    logic                r_in_ready, w_in_ready;
    logic                r_out_valid, w_out_valid;
    logic [39:0]         r_out_data, w_out_data;
    logic                r_out_ovf, w_out_ovf;
    logic                r_busy, w_busy;
    logic                w_hs;
    logic [8:0]          w_top9;
    logic                w_ovf;

    assign w_hs   = r_in_ready & in_valid;
    // Overflow when the nine bits above the 31-bit magnitude disagree.
    assign w_top9 = {mac_protect, mac_result[31]};
    assign w_ovf  = ~(&w_top9 | ~|w_top9);

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_first     = r_first;
        w_sat_en    = r_sat_en;
        w_wcnt      = r_wcnt;
        w_instr     = OP_CLR;
        w_mult      = 16'h0000;
        w_mcand     = 16'h0000;
        w_stall     = 1'b1;
        w_in_ready  = 1'b0;
        w_out_valid = r_out_valid;
        w_out_data  = r_out_data;
        w_out_ovf   = r_out_ovf;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        w_state    = S_RUN;
                        w_cnt      = len;
                        w_first    = 1'b1;
                        w_sat_en   = sat_en;
                        w_in_ready = 1'b1;
                    end else begin
                        w_state     = S_HOLD;
                        w_out_valid = 1'b1;
                        w_out_data  = 40'h0;
                        w_out_ovf   = 1'b0;
                    end
                end
            end
            S_RUN: begin
                w_in_ready = 1'b1;
                if (w_hs) begin
                    w_instr = r_first ? OP_MUL : OP_ACC;
                    w_mult  = in_a;
                    w_mcand = in_b;
                    w_stall = 1'b0;
                    w_first = 1'b0;
                    w_cnt   = r_cnt - 1'b1;
                    if (r_cnt == LEN_W'(1)) begin
                        w_in_ready = 1'b0;
                        w_state    = S_DRAIN;
                    end
                end else begin
                    // Idle cycles accumulate zero; before the first pair they clear instead.
                    w_instr = r_first ? OP_CLR : OP_ACC;
                end
            end
            S_DRAIN: begin
                w_instr = r_sat_en ? OP_SAT : OP_ACC;
                w_stall = 1'b0;
                w_wcnt  = WCNT_W'(MAC_LAT);
                w_state = S_WAIT;
            end
            S_WAIT: begin
                w_instr = OP_ACC;
                if (r_wcnt == '0) begin
                    w_out_data  = {mac_protect, mac_result};
                    w_out_ovf   = w_ovf;
                    w_out_valid = 1'b1;
                    w_state     = S_HOLD;
                end else begin
                    w_wcnt = r_wcnt - 1'b1;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_out_valid = 1'b0;
                    w_state     = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase
        w_busy = (w_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_first     <= 1'b0;
            r_sat_en    <= 1'b0;
            r_wcnt      <= '0;
            r_instr     <= OP_CLR;
            r_mult      <= 16'h0000;
            r_mcand     <= 16'h0000;
            r_stall     <= 1'b1;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 40'h0;
            r_out_ovf   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_first     <= w_first;
            r_sat_en    <= w_sat_en;
            r_wcnt      <= w_wcnt;
            r_instr     <= w_instr;
            r_mult      <= w_mult;
            r_mcand     <= w_mcand;
            r_stall     <= w_stall;
            r_in_ready  <= w_in_ready;
            r_out_valid <= w_out_valid;
            r_out_data  <= w_out_data;
            r_out_ovf   <= w_out_ovf;
            r_busy      <= w_busy;
        end
    end

    assign in_ready         = r_in_ready;
    assign mac_instruction  = r_instr;
    assign mac_multiplier   = r_mult;
    assign mac_multiplicand = r_mcand;
    assign mac_stall        = r_stall;
    assign out_valid        = r_out_valid;
    assign out_data         = r_out_data;
    assign out_ovf          = r_out_ovf;
    assign busy             = r_busy;

endmodule
